// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state encoding, index-width helper and default operand width for the multiplier arbiter
package mult_arb_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_RESP} state_e;
  function automatic int idw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request/response bus between client blocks and the shared multiplier arbiter
interface mult_arbiter_if import mult_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WIDTH = DEF_WIDTH
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] resp_ready;
  logic [2*WIDTH-1:0] resp_p;
  modport master (output req_valid, req_a, req_b, resp_ready, input req_ready, resp_valid, resp_p);
  modport slave (input req_valid, req_a, req_b, resp_ready, output req_ready, resp_valid, resp_p);
endinterface

// File: rtl/MultiplierOperator.sv
// MultiplierOperator: combinational full-width signed multiplier
module MultiplierOperator #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  output logic signed [2*WIDTH-1:0] P
);
  assign P = A * B;
endmodule

// File: rtl/mult_rr_pick.sv
// mult_rr_pick: combinational round-robin picker, first set request at or above ptr modulo NREQ
module mult_rr_pick import mult_arb_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);
  logic [NREQ-1:0] rot;
  logic [IDW:0] off;
  logic [IDW:0] sum;
  always_comb begin
    rot = NREQ'({req_i, req_i} >> ptr_i);
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) off = (IDW+1)'(k);
    sum = off + {1'b0, ptr_i};
    gnt_id_o = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
  end
  assign any_o = |req_i;
  assign grant_o = any_o ? NREQ'(1) << gnt_id_o : '0;
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one signed multiplier among NREQ requesters with round-robin grants
module mult_arbiter import mult_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_arbiter_if.slave bus,
  output logic          busy_o,
  output logic [31:0]   ops_done_o
);
  localparam int IDW = idw(NREQ);
  state_e state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] gnt_id;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] resp_valid_q;
  logic any;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic signed [WIDTH-1:0] a_arr [NREQ];
  logic signed [WIDTH-1:0] b_arr [NREQ];
  logic signed [2*WIDTH-1:0] p;
  logic signed [2*WIDTH-1:0] p_q;
  logic [31:0] ops_done_q;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
  end
  mult_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i(bus.req_valid),
    .ptr_i(ptr_q),
    .grant_o(grant),
    .gnt_id_o(gnt_id),
    .any_o(any)
  );
  MultiplierOperator #(.WIDTH(WIDTH)) u_mul (.A(a_q), .B(b_q), .P(p));
  assign bus.req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_p = p_q;
  assign busy_o = state_q != ST_IDLE;
  assign ops_done_o = ops_done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      resp_valid_q <= '0;
      ops_done_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (any) begin
          a_q <= a_arr[gnt_id];
          b_q <= b_arr[gnt_id];
          id_q <= gnt_id;
          ptr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          p_q <= p;
          resp_valid_q <= NREQ'(1) << id_q;
          state_q <= ST_RESP;
        end
        ST_RESP: if (bus.resp_ready[id_q]) begin
          resp_valid_q <= '0;
          ops_done_q <= ops_done_q + 32'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and randomized checks of the shared multiplier arbiter against a behavioural model
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [31:0] ops_done;
  logic [N-1:0] vmask = '0;
  logic [N-1:0] rdy = '0;
  logic signed [W-1:0] opa [N];
  logic signed [W-1:0] opb [N];
  int passed = 0;
  int total = 0;
  int m_ptr = 0;
  int m_ops = 0;
  mult_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();
  mult_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy_o(busy),
    .ops_done_o(ops_done)
  );
  always #5 clk = ~clk;
  assign bus.req_valid = vmask;
  assign bus.resp_ready = rdy;
  for (genvar i = 0; i < N; i++) begin : g_ops
    assign bus.req_a[i*W +: W] = opa[i];
    assign bus.req_b[i*W +: W] = opb[i];
  end
  function automatic logic [N-1:0] oh(int i);
    return N'(1) << i;
  endfunction
  function automatic int pick(logic [N-1:0] m, int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [63:0] prod(logic signed [W-1:0] a, logic signed [W-1:0] b);
    longint r;
    r = longint'(a) * longint'(b);
    return r;
  endfunction
  always begin
    @(posedge clk);
    #3;
    if (rst_n) begin
      total++;
      if ((|bus.req_ready) && (|bus.resp_valid)) $display("FAIL excl: req_ready=%b resp_valid=%b, required not both nonzero", bus.req_ready, bus.resp_valid);
      else passed++;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end
  task automatic do_reset();
    @(negedge clk);
    vmask = '0;
    rdy = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_ops = 0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== '0 || bus.resp_valid !== '0) $display("FAIL reset_hs: req_ready=%b resp_valid=%b, required 0000/0000", bus.req_ready, bus.resp_valid);
    else passed++;
    total++;
    if (bus.resp_p !== 64'd0) $display("FAIL reset_p: resp_p=%h, required 0", bus.resp_p);
    else passed++;
    total++;
    if (busy !== 1'b0 || ops_done !== 32'd0) $display("FAIL reset_cnt: busy=%b ops_done=%0d, required 0/0", busy, ops_done);
    else passed++;
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    do_reset();
    opa[0] = 5;
    opb[0] = -5;
    vmask = 4'b0001;
    rdy = 4'hF;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL single_ready: got %b, required 0001", bus.req_ready);
    else passed++;
    @(negedge clk);
    vmask = '0;
    #1;
    total++;
    if (busy !== 1'b1 || bus.resp_valid !== '0 || bus.req_ready !== '0) $display("FAIL single_calc: busy=%b resp_valid=%b req_ready=%b, required 1/0000/0000", busy, bus.resp_valid, bus.req_ready);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_p !== 64'hFFFFFFFFFFFFFFE7) $display("FAIL single_resp: resp_valid=%b resp_p=%h, required 0001/ffffffffffffffe7", bus.resp_valid, bus.resp_p);
    else passed++;
    @(negedge clk);
    total++;
    if (ops_done !== 32'd1 || bus.resp_valid !== '0 || busy !== 1'b0) $display("FAIL single_done: ops_done=%0d resp_valid=%b busy=%b, required 1/0000/0", ops_done, bus.resp_valid, busy);
    else passed++;
  endtask
  task automatic test_round_robin();
    do_reset();
    opa[0] = 5;  opb[0] = 5;
    opa[1] = -5; opb[1] = -5;
    opa[2] = -5; opb[2] = 5;
    opa[3] = 0;  opb[3] = -5;
    vmask = 4'hF;
    rdy = 4'hF;
    for (int g = 0; g < N; g++) begin
      logic [63:0] ep;
      ep = prod(opa[g], opb[g]);
      #1;
      total++;
      if (bus.req_ready !== oh(g)) $display("FAIL rr_grant%0d: req_ready=%b, required %b", g, bus.req_ready, oh(g));
      else passed++;
      @(negedge clk);
      vmask[g] = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== '0) $display("FAIL rr_calc%0d: req_ready=%b, required 0000", g, bus.req_ready);
      else passed++;
      @(negedge clk);
      total++;
      if (bus.resp_valid !== oh(g) || bus.resp_p !== ep) $display("FAIL rr_resp%0d: resp_valid=%b resp_p=%h, required %b/%h", g, bus.resp_valid, bus.resp_p, oh(g), ep);
      else passed++;
      @(negedge clk);
      m_ops++;
      m_ptr = (g + 1) % N;
      total++;
      if (ops_done !== 32'(m_ops)) $display("FAIL rr_ops%0d: ops_done=%0d, required %0d", g, ops_done, m_ops);
      else passed++;
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    opa[2] = -12;
    opb[2] = 6;
    vmask = 4'b0100;
    rdy = '0;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) $display("FAIL bp_grant: req_ready=%b, required 0100", bus.req_ready);
    else passed++;
    @(negedge clk);
    opa[1] = 3;
    opb[1] = 7;
    vmask = 4'b0010;
    #1;
    total++;
    if (bus.req_ready !== '0) $display("FAIL bp_calc: req_ready=%b, required 0000", bus.req_ready);
    else passed++;
    @(negedge clk);
    rdy = 4'b1011;
    for (int h = 0; h < 6; h++) begin
      #1;
      total++;
      if (bus.resp_valid !== 4'b0100 || bus.resp_p !== 64'hFFFFFFFFFFFFFFB8 || bus.req_ready !== '0) $display("FAIL bp_hold%0d: resp_valid=%b resp_p=%h req_ready=%b, required 0100/ffffffffffffffb8/0000", h, bus.resp_valid, bus.resp_p, bus.req_ready);
      else passed++;
      if (h < 5) @(negedge clk);
    end
    rdy = 4'b0100;
    @(negedge clk);
    #1;
    total++;
    if (bus.resp_valid !== '0 || ops_done !== 32'd1 || bus.req_ready !== 4'b0010) $display("FAIL bp_next: resp_valid=%b ops_done=%0d req_ready=%b, required 0000/1/0010", bus.resp_valid, ops_done, bus.req_ready);
    else passed++;
    rdy = 4'b0010;
    @(negedge clk);
    vmask = '0;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 4'b0010 || bus.resp_p !== 64'd21) $display("FAIL bp_resp1: resp_valid=%b resp_p=%h, required 0010/15", bus.resp_valid, bus.resp_p);
    else passed++;
    @(negedge clk);
    total++;
    if (ops_done !== 32'd2) $display("FAIL bp_ops: ops_done=%0d, required 2", ops_done);
    else passed++;
  endtask
  task automatic test_wrap();
    do_reset();
    opa[3] = 7;
    opb[3] = -3;
    vmask = 4'b1000;
    rdy = 4'hF;
    #1;
    total++;
    if (bus.req_ready !== 4'b1000) $display("FAIL wrap_g3: req_ready=%b, required 1000", bus.req_ready);
    else passed++;
    @(negedge clk);
    vmask = '0;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 4'b1000 || bus.resp_p !== 64'hFFFFFFFFFFFFFFEB) $display("FAIL wrap_r3: resp_valid=%b resp_p=%h, required 1000/ffffffffffffffeb", bus.resp_valid, bus.resp_p);
    else passed++;
    @(negedge clk);
    opa[0] = 2;
    opb[0] = 2;
    vmask = 4'b1001;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL wrap_g0: req_ready=%b, required 0001", bus.req_ready);
    else passed++;
    @(negedge clk);
    vmask = 4'b1000;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_p !== 64'd4) $display("FAIL wrap_r0: resp_valid=%b resp_p=%h, required 0001/4", bus.resp_valid, bus.resp_p);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (bus.req_ready !== 4'b1000) $display("FAIL wrap_again3: req_ready=%b, required 1000", bus.req_ready);
    else passed++;
    @(negedge clk);
    vmask = '0;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    do_reset();
    opa[0] = 8;
    opb[0] = 6;
    vmask = 4'b0001;
    rdy = 4'hF;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL rmid_grant: req_ready=%b, required 0001", bus.req_ready);
    else passed++;
    @(negedge clk);
    vmask = '0;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || bus.resp_valid !== '0 || ops_done !== 32'd0) $display("FAIL rmid_rst: busy=%b resp_valid=%b ops_done=%0d, required 0/0000/0", busy, bus.resp_valid, ops_done);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      total++;
      if (bus.resp_valid !== '0 || busy !== 1'b0 || ops_done !== 32'd0) $display("FAIL rmid_quiet%0d: resp_valid=%b busy=%b ops_done=%0d, required 0000/0/0", h, bus.resp_valid, busy, ops_done);
      else passed++;
    end
    opa[1] = 3;
    opb[1] = 3;
    vmask = 4'b0011;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL rmid_ptr: req_ready=%b, required 0001", bus.req_ready);
    else passed++;
    @(negedge clk);
    vmask = '0;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_p !== 64'd48) $display("FAIL rmid_resp: resp_valid=%b resp_p=%h, required 0001/30", bus.resp_valid, bus.resp_p);
    else passed++;
    @(negedge clk);
  endtask
  task automatic test_random();
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int w;
      int hold;
      logic [63:0] ep;
      vmask = N'($urandom);
      rdy = N'($urandom);
      for (int i = 0; i < N; i++) begin
        opa[i] = $urandom;
        opb[i] = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
        if ($urandom_range(0, 5) == 0) opa[i] = '0;
      end
      #1;
      w = pick(vmask, m_ptr);
      if (w < 0) begin
        total++;
        if (bus.req_ready !== '0) $display("FAIL rnd_idle%0d: req_ready=%b, required 0000", it, bus.req_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL rnd_nobusy%0d: busy=%b, required 0", it, busy);
        else passed++;
        continue;
      end
      ep = prod(opa[w], opb[w]);
      hold = $urandom_range(0, 3);
      total++;
      if (bus.req_ready !== oh(w)) $display("FAIL rnd_grant%0d: req_ready=%b, required %b", it, bus.req_ready, oh(w));
      else passed++;
      @(negedge clk);
      vmask[w] = 1'b0;
      rdy = N'($urandom);
      rdy[w] = (hold == 0);
      #1;
      total++;
      if (bus.req_ready !== '0 || busy !== 1'b1) $display("FAIL rnd_calc%0d: req_ready=%b busy=%b, required 0000/1", it, bus.req_ready, busy);
      else passed++;
      @(negedge clk);
      total++;
      if (bus.resp_valid !== oh(w) || bus.resp_p !== ep) $display("FAIL rnd_resp%0d: resp_valid=%b resp_p=%h, required %b/%h", it, bus.resp_valid, bus.resp_p, oh(w), ep);
      else passed++;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        total++;
        if (bus.resp_valid !== oh(w) || bus.resp_p !== ep || bus.req_ready !== '0) $display("FAIL rnd_hold%0d: resp_valid=%b resp_p=%h req_ready=%b, required %b/%h/0000", it, bus.resp_valid, bus.resp_p, bus.req_ready, oh(w), ep);
        else passed++;
      end
      rdy[w] = 1'b1;
      @(negedge clk);
      m_ptr = (w + 1) % N;
      m_ops++;
      total++;
      if (ops_done !== 32'(m_ops) || bus.resp_valid !== '0) $display("FAIL rnd_done%0d: ops_done=%0d resp_valid=%b, required %0d/0000", it, ops_done, bus.resp_valid, m_ops);
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
